// File: rtl/if_prefetch_queue.sv
// Instruction-fetch prefetch queue.
// Owns the fetch PC, issues one outstanding word read at a time over a req/ack
// handshake, and buffers up to DEPTH fetched words (with PC+4) for the IF/ID
// register behind a valid/ready interface. A redirect flushes the queue and
// restarts fetch; a read already on the bus is drained (DROP) before refetching.

// One queue slot: instruction word plus its PC+4.
module if_pq_entry (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [31:0] d_data,
  input  logic [31:0] d_pc4,
  output logic [31:0] q_data,
  output logic [31:0] q_pc4
);

  // Slot storage, cleared on reset, written on push to this slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_data <= '0;
      q_pc4  <= '0;
    end else if (we) begin
      q_data <= d_data;
      q_pc4  <= d_pc4;
    end
  end

endmodule

module if_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          AW       = 10,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic                     mem_req,
  output logic [AW-1:0]            mem_addr,
  input  logic                     mem_ack,
  input  logic [31:0]              mem_rdata,
  output logic                     inst_valid,
  output logic [31:0]              inst_data,
  output logic [31:0]              inst_pc4,
  input  logic                     inst_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t              state, state_nx;
  logic [31:0]         fetch_pc, fetch_pc_nx;
  logic [AW-1:0]       hold_addr, hold_addr_nx;
  logic [31:0]         rpc;
  logic [CW-1:0]       post_cnt;
  logic                push, pop;
  logic [PW-1:0]       wr_ptr, rd_ptr;

  logic [DEPTH-1:0][31:0] ent_data;
  logic [DEPTH-1:0][31:0] ent_pc4;

  // Low PC bits of the redirect target are not part of the word address.
  logic unused_rpc_lo;
  assign unused_rpc_lo = ^redirect_pc[1:0];
  assign rpc           = {redirect_pc[31:2], 2'b00};

  assign inst_valid = (count != '0);
  // A pop in a redirect cycle is void: the consumer flushes on the same redirect.
  assign pop        = inst_valid & inst_ready & ~redirect;
  // Occupancy after this cycle if a push happens now.
  assign post_cnt   = count + CW'(1) - CW'(pop);

  // While draining an abandoned read, the bus address must stay on the old word.
  assign mem_addr   = (state == DROP) ? hold_addr : fetch_pc[AW+1:2];

  // Next-state, fetch PC update, push strobe and bus request.
  always_comb begin
    state_nx     = state;
    fetch_pc_nx  = fetch_pc;
    hold_addr_nx = hold_addr;
    push         = 1'b0;
    mem_req      = 1'b0;
    case (state)
      IDLE: begin
        if (redirect) begin
          fetch_pc_nx = rpc;
          state_nx    = REQ;
        end else if (count < CW'(DEPTH)) begin
          state_nx = REQ;
        end
      end
      REQ: begin
        mem_req = 1'b1;
        if (redirect) begin
          fetch_pc_nx = rpc;
          if (!mem_ack) begin
            hold_addr_nx = fetch_pc[AW+1:2];
            state_nx     = DROP;
          end
        end else if (mem_ack) begin
          push        = 1'b1;
          fetch_pc_nx = fetch_pc + 32'd4;
          state_nx    = (post_cnt < CW'(DEPTH)) ? REQ : IDLE;
        end
      end
      DROP: begin
        mem_req = 1'b1;
        if (redirect) fetch_pc_nx = rpc;
        if (mem_ack)  state_nx    = REQ;
      end
      default: state_nx = IDLE;
    endcase
  end

  // FSM state, fetch PC and held DROP address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      hold_addr <= '0;
    end else begin
      state     <= state_nx;
      fetch_pc  <= fetch_pc_nx;
      hold_addr <= hold_addr_nx;
    end
  end

  // Circular pointers and occupancy; redirect clears everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    if_pq_entry u_ent (
      .clk    (clk),
      .rst    (rst),
      .we     (push && (wr_ptr == PW'(g))),
      .d_data (mem_rdata),
      .d_pc4  (fetch_pc + 32'd4),
      .q_data (ent_data[g]),
      .q_pc4  (ent_pc4[g])
    );
  end

  assign inst_data = ent_data[rd_ptr];
  assign inst_pc4  = ent_pc4[rd_ptr];

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for if_prefetch_queue with a variable-latency memory responder.
module tb_if_prefetch_queue;

  localparam int AW = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        inst_ready = 1'b0;
  wire         mem_req;
  wire [AW-1:0] mem_addr;
  wire         mem_ack;
  wire [31:0]  mem_rdata;
  wire         inst_valid;
  wire [31:0]  inst_data;
  wire [31:0]  inst_pc4;
  wire [2:0]   count;

  logic        auto_en = 1'b1;
  logic        auto_ack = 1'b0;
  logic        stray_ack = 1'b0;
  logic [31:0] rd_auto = 32'h0;
  int          lat = 1;
  int          wc = 0;
  int          errors = 0;
  int          checks = 0;

  assign mem_ack   = auto_ack | stray_ack;
  assign mem_rdata = stray_ack ? 32'hDEAD_BEEF : rd_auto;

  if_prefetch_queue #(.DEPTH(4), .AW(AW), .RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc4(inst_pc4),
    .inst_ready(inst_ready), .count(count)
  );

  always #5 clk = ~clk;

  // Memory: acks on the lat-th cycle of a request; data = tag + word address.
  initial begin
    forever begin
      @(negedge clk);
      if (auto_en && mem_req) begin
        if (wc >= lat - 1) begin
          auto_ack = 1'b1;
          rd_auto  = 32'h1000_0000 + {22'd0, mem_addr};
          wc       = 0;
        end else begin
          auto_ack = 1'b0;
          wc++;
        end
      end else begin
        auto_ack = 1'b0;
        wc       = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] tag(input logic [31:0] pc4);
    logic [31:0] pc;
    pc  = pc4 - 32'd4;
    tag = 32'h1000_0000 + {22'd0, pc[11:2]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_count(input logic [2:0] n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (count == n) begin ok = 1'b1; break; end
      step();
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (inst_valid) begin ok = 1'b1; break; end
      step();
    end
  endtask

  task automatic test_reset_stream();
    logic [31:0] exp;
    #12;
    checks++; if (mem_req !== 1'b0)     begin errors++; $display("FAIL rst_mem_req: got %b exp 0", mem_req); end
    checks++; if (mem_addr !== 10'h000) begin errors++; $display("FAIL rst_mem_addr: got %h exp 000", mem_addr); end
    checks++; if (inst_valid !== 1'b0)  begin errors++; $display("FAIL rst_valid: got %b exp 0", inst_valid); end
    checks++; if (inst_data !== 32'h0)  begin errors++; $display("FAIL rst_data: got %h exp 0", inst_data); end
    checks++; if (inst_pc4 !== 32'h0)   begin errors++; $display("FAIL rst_pc4: got %h exp 0", inst_pc4); end
    checks++; if (count !== 3'd0)       begin errors++; $display("FAIL rst_count: got %0d exp 0", count); end
    step();
    rst = 1'b1;
    step();
    checks++; if (mem_req !== 1'b1 || inst_valid !== 1'b0) begin
      errors++; $display("FAIL t1_first_req: req=%b valid=%b exp req=1 valid=0", mem_req, inst_valid); end
    inst_ready = 1'b1;
    step();
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL t1_latency: valid=%b exp 1", inst_valid); end
    exp = 32'h3004;
    for (int i = 0; i < 8; i++) begin
      checks++; if (inst_valid !== 1'b1 || inst_pc4 !== exp || inst_data !== tag(exp)) begin
        errors++; $display("FAIL t1_stream: valid=%b pc4=%h data=%h exp pc4=%h data=%h", inst_valid, inst_pc4, inst_data, exp, tag(exp)); end
      exp += 4;
      step();
    end
  endtask

  task automatic test_full_stall();
    logic [31:0] exp;
    bit ok;
    inst_ready = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h3000;
    step();
    redirect = 1'b0;
    wait_count(3'd4, ok);
    checks++; if (!ok) begin errors++; $display("FAIL t2_fill: count=%0d exp 4", count); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (mem_req !== 1'b0 || count !== 3'd4) begin
        errors++; $display("FAIL t2_full_hold: req=%b count=%0d exp req=0 count=4", mem_req, count); end
      step();
    end
    inst_ready = 1'b1;
    exp = 32'h3004;
    for (int i = 0; i < 16; i++) begin
      checks++; if (inst_valid !== 1'b1 || inst_pc4 !== exp || inst_data !== tag(exp)) begin
        errors++; $display("FAIL t2_drain: valid=%b pc4=%h data=%h exp pc4=%h", inst_valid, inst_pc4, inst_data, exp); end
      exp += 4;
      step();
    end
  endtask

  task automatic test_redirect_drop();
    bit ok;
    inst_ready = 1'b0;
    wait_count(3'd4, ok);
    checks++; if (!ok) begin errors++; $display("FAIL t3_fill: count=%0d exp 4", count); end
    lat = 3;
    redirect = 1'b1; redirect_pc = 32'h3000;
    step();
    redirect_pc = 32'h3100;
    step();
    redirect = 1'b0;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 10'h000) begin
      errors++; $display("FAIL t3_drop_hold: req=%b addr=%h exp req=1 addr=000", mem_req, mem_addr); end
    step();
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL t3_no_stale_a: valid=%b exp 0", inst_valid); end
    step();
    checks++; if (mem_addr !== 10'h040 || inst_valid !== 1'b0 || count !== 3'd0) begin
      errors++; $display("FAIL t3_after_drop: addr=%h valid=%b count=%0d exp addr=040 valid=0 count=0", mem_addr, inst_valid, count); end
    wait_valid(ok);
    checks++; if (!ok || inst_pc4 !== 32'h3104 || inst_data !== 32'h1000_0040) begin
      errors++; $display("FAIL t3_first: ok=%b pc4=%h data=%h exp pc4=3104 data=10000040", ok, inst_pc4, inst_data); end
  endtask

  task automatic test_redirect_ack_pop();
    bit ok;
    lat = 1;
    inst_ready = 1'b0;
    wait_count(3'd4, ok);
    redirect = 1'b1; redirect_pc = 32'h3000;
    step();
    redirect = 1'b0;
    wait_count(3'd2, ok);
    checks++; if (!ok) begin errors++; $display("FAIL t4_fill: count=%0d exp 2", count); end
    redirect = 1'b1; redirect_pc = 32'h3200; inst_ready = 1'b1;
    step();
    redirect = 1'b0;
    checks++; if (count !== 3'd0 || inst_valid !== 1'b0) begin
      errors++; $display("FAIL t4_flush: count=%0d valid=%b exp 0 0", count, inst_valid); end
    checks++; if (mem_req !== 1'b1 || mem_addr !== 10'h080) begin
      errors++; $display("FAIL t4_refetch: req=%b addr=%h exp req=1 addr=080", mem_req, mem_addr); end
    step();
    checks++; if (inst_valid !== 1'b1 || inst_pc4 !== 32'h3204 || inst_data !== 32'h1000_0080) begin
      errors++; $display("FAIL t4_first: valid=%b pc4=%h data=%h exp 1 3204 10000080", inst_valid, inst_pc4, inst_data); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    bit ok;
    inst_ready = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h3000;
    step();
    redirect = 1'b0;
    wait_count(3'd3, ok);
    checks++; if (!ok) begin errors++; $display("FAIL t5_fill: count=%0d exp 3", count); end
    inst_ready = 1'b1;
    exp = 32'h3004;
    for (int i = 0; i < 14; i++) begin
      checks++; if (count !== 3'd3 || inst_pc4 !== exp || inst_data !== tag(exp)) begin
        errors++; $display("FAIL t5_wrap: count=%0d pc4=%h data=%h exp count=3 pc4=%h", count, inst_pc4, inst_data, exp); end
      exp += 4;
      step();
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    lat = 3;
    inst_ready = 1'b0;
    step();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL t6_mid_req: req=%b exp 1", mem_req); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0 || inst_valid !== 1'b0 || count !== 3'd0 || mem_addr !== 10'h000) begin
      errors++; $display("FAIL t6_async: req=%b valid=%b count=%0d addr=%h exp 0 0 0 000", mem_req, inst_valid, count, mem_addr); end
    auto_en = 1'b0;
    step();
    rst = 1'b1;
    stray_ack = 1'b1;
    step();
    stray_ack = 1'b0;
    checks++; if (count !== 3'd0 || inst_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 10'h000) begin
      errors++; $display("FAIL t6_stray: count=%0d valid=%b req=%b addr=%h exp 0 0 1 000", count, inst_valid, mem_req, mem_addr); end
    lat = 1;
    auto_en = 1'b1;
    wait_valid(ok);
    checks++; if (!ok || inst_pc4 !== 32'h3004 || inst_data !== 32'h1000_0000) begin
      errors++; $display("FAIL t6_restart: ok=%b pc4=%h data=%h exp 3004 10000000", ok, inst_pc4, inst_data); end
  endtask

  initial begin
    test_reset_stream();
    test_full_stall();
    test_redirect_drop();
    test_redirect_ack_pop();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
